// File: rtl/keypad_entry.sv
// Keypad entry controller: decodes matrix-scanner key codes into a 4-digit BCD entry
// with repeat suppression, backspace/clear/enter handling and an idle timeout.
module keypad_entry #(
   parameter int unsigned REPEAT_HOLD = 20000,
   parameter int unsigned TIMEOUT     = 5000000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [3:0]  i_key_code,
   input  logic        i_data_ready,
   output logic [15:0] o_value,
   output logic [2:0]  o_digit_count,
   output logic [15:0] o_entry_value,
   output logic        o_entry_valid,
   output logic        o_error
);

   localparam int unsigned HoldW    = (REPEAT_HOLD > 2) ? $clog2(REPEAT_HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(REPEAT_HOLD - 1);
   localparam logic [23:0]      TmoLast  = 24'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StEntry, StFull} state_t;

   state_t            r_state, w_state_d;
   logic [15:0]       r_value, w_value_d;
   logic [2:0]        r_count, w_count_d;
   logic [15:0]       r_entry, w_entry_d;
   logic              r_valid, w_valid_d;
   logic              r_error, w_error_d;
   logic [HoldW-1:0]  r_hold, w_hold_d;
   logic [23:0]       r_tmo, w_tmo_d;
   logic [3:0]        r_last, w_last_d;

   logic              w_accept;
   logic              w_is_digit, w_is_enter, w_is_clear, w_is_back;
   logic [3:0]        w_digit;

   // Scanner code (row*4+col) to key role; A/B/C decode to nothing.
   always_comb begin
      w_is_digit = 1'b1;
      w_is_enter = 1'b0;
      w_is_clear = 1'b0;
      w_is_back  = 1'b0;
      w_digit    = 4'h0;
      case (i_key_code)
         4'd0:    w_digit = 4'd1;
         4'd1:    w_digit = 4'd2;
         4'd2:    w_digit = 4'd3;
         4'd4:    w_digit = 4'd4;
         4'd5:    w_digit = 4'd5;
         4'd6:    w_digit = 4'd6;
         4'd8:    w_digit = 4'd7;
         4'd9:    w_digit = 4'd8;
         4'd10:   w_digit = 4'd9;
         4'd13:   w_digit = 4'd0;
         4'd12:   begin w_is_digit = 1'b0; w_is_clear = 1'b1; end
         4'd14:   begin w_is_digit = 1'b0; w_is_enter = 1'b1; end
         4'd15:   begin w_is_digit = 1'b0; w_is_back  = 1'b1; end
         default: w_is_digit = 1'b0;
      endcase
   end

   assign w_accept = i_data_ready && !((i_key_code == r_last) && (r_hold != '0));

   always_comb begin
      w_state_d = r_state;
      w_value_d = r_value;
      w_count_d = r_count;
      w_entry_d = r_entry;
      w_valid_d = 1'b0;
      w_error_d = 1'b0;
      w_last_d  = r_last;
      w_tmo_d   = r_tmo;
      w_hold_d  = (r_hold != '0) ? r_hold - HoldW'(1) : '0;

      if (w_accept) begin
         // Every accepted key, including ignored A/B/C, restarts hold and timeout.
         w_last_d = i_key_code;
         w_hold_d = HoldLoad;
         w_tmo_d  = '0;
         if (w_is_digit) begin
            if (r_state == StFull) begin
               w_error_d = 1'b1;
            end else begin
               w_value_d = {r_value[11:0], w_digit};
               w_count_d = r_count + 3'd1;
               w_state_d = (r_count == 3'd3) ? StFull : StEntry;
            end
         end else if (w_is_enter) begin
            if (r_state == StIdle) begin
               w_error_d = 1'b1;
            end else begin
               w_entry_d = r_value;
               w_valid_d = 1'b1;
               w_value_d = '0;
               w_count_d = '0;
               w_state_d = StIdle;
            end
         end else if (w_is_clear) begin
            w_value_d = '0;
            w_count_d = '0;
            w_state_d = StIdle;
         end else if (w_is_back && (r_state != StIdle)) begin
            w_value_d = {4'h0, r_value[15:4]};
            w_count_d = r_count - 3'd1;
            w_state_d = (r_count == 3'd1) ? StIdle : StEntry;
         end
      end else if (r_count != '0) begin
         if (r_tmo == TmoLast) begin
            w_value_d = '0;
            w_count_d = '0;
            w_tmo_d   = '0;
            w_state_d = StIdle;
         end else begin
            w_tmo_d = r_tmo + 24'd1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_value <= '0;
         r_count <= '0;
         r_entry <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_hold  <= '0;
         r_tmo   <= '0;
         r_last  <= '0;
      end else begin
         r_state <= w_state_d;
         r_value <= w_value_d;
         r_count <= w_count_d;
         r_entry <= w_entry_d;
         r_valid <= w_valid_d;
         r_error <= w_error_d;
         r_hold  <= w_hold_d;
         r_tmo   <= w_tmo_d;
         r_last  <= w_last_d;
      end
   end

   assign o_value       = r_value;
   assign o_digit_count = r_count;
   assign o_entry_value = r_entry;
   assign o_entry_valid = r_valid;
   assign o_error       = r_error;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: hand-computed expectations checked with immediate assertions.
module tb_keypad_entry;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic [3:0]  i_key_code;
   logic        i_data_ready;
   logic [15:0] o_value;
   logic [2:0]  o_digit_count;
   logic [15:0] o_entry_value;
   logic        o_entry_valid;
   logic        o_error;

   int n_cmp  = 0;
   int n_fail = 0;
   logic p_valid, p_error, seen_pulse;

   keypad_entry #(.REPEAT_HOLD(20000), .TIMEOUT(1000)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_key_code    (i_key_code),
      .i_data_ready  (i_data_ready),
      .o_value       (o_value),
      .o_digit_count (o_digit_count),
      .o_entry_value (o_entry_value),
      .o_entry_valid (o_entry_valid),
      .o_error       (o_error)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; one strobe cycle, pulses captured right after the edge.
   task automatic strobe(input logic [3:0] code);
      i_key_code   = code;
      i_data_ready = 1'b1;
      @(negedge i_clock);
      i_data_ready = 1'b0;
      p_valid      = o_entry_valid;
      p_error      = o_error;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clock);
   endtask

   initial begin
      i_reset      = 1'b1;
      i_key_code   = 4'd0;
      i_data_ready = 1'b0;
      idle(3);
      i_reset = 1'b0;
      chk("rst_value", o_value, 0);
      chk("rst_count", o_digit_count, 0);
      chk("rst_entry", o_entry_value, 0);
      chk("rst_valid", o_entry_valid, 0);
      chk("rst_error", o_error, 0);

      // Enter 1,2,3 then #
      strobe(4'd0); idle(5);
      strobe(4'd1); idle(5);
      strobe(4'd2); idle(5);
      chk("123_value", o_value, 32'h0123);
      chk("123_count", o_digit_count, 3);
      strobe(4'd14);
      chk("enter_valid", p_valid, 1);
      chk("enter_error", p_error, 0);
      chk("enter_entry", o_entry_value, 32'h0123);
      chk("enter_count", o_digit_count, 0);
      chk("enter_value", o_value, 0);
      idle(1);
      chk("enter_valid_low", o_entry_valid, 0);

      // Codes 13,4,9,10 map to digits 0,4,8,9; fifth digit overflows
      strobe(4'd13); strobe(4'd4); strobe(4'd9); strobe(4'd10);
      chk("full_value", o_value, 32'h0489);
      chk("full_count", o_digit_count, 4);
      strobe(4'd5);
      chk("ovf_error", p_error, 1);
      chk("ovf_valid", p_valid, 0);
      chk("ovf_value", o_value, 32'h0489);
      chk("ovf_count", o_digit_count, 4);
      idle(1);
      chk("ovf_error_low", o_error, 0);
      strobe(4'd15);
      chk("full_back_value", o_value, 32'h0048);
      chk("full_back_count", o_digit_count, 3);
      strobe(4'd12);
      chk("clr_value", o_value, 0);
      chk("clr_count", o_digit_count, 0);
      chk("clr_pulse", {p_valid, p_error}, 0);

      // Repeat suppression: 100 cycles apart -> one digit
      strobe(4'd5); idle(99); strobe(4'd5);
      chk("rep100_count", o_digit_count, 1);
      chk("rep100_value", o_value, 32'h0005);
      strobe(4'd12);
      strobe(4'd5);
      chk("rep_first_count", o_digit_count, 1);
      idle(19998);
      chk("rep_tmo_count", o_digit_count, 0);
      strobe(4'd5);
      chk("rep19999_count", o_digit_count, 0);
      idle(1);
      strobe(4'd5);
      chk("rep20001_count", o_digit_count, 1);
      chk("rep20001_value", o_value, 32'h0005);

      // data_ready held for several cycles is a single acceptance
      strobe(4'd12);
      i_key_code   = 4'd0;
      i_data_ready = 1'b1;
      idle(5);
      i_data_ready = 1'b0;
      chk("held_count", o_digit_count, 1);
      chk("held_value", o_value, 32'h0001);

      // Digits 1,2, backspace, clear; backspace in idle is silent
      strobe(4'd12);
      strobe(4'd0); strobe(4'd1);
      chk("bs_pre_value", o_value, 32'h0012);
      strobe(4'd15);
      chk("bs_value", o_value, 32'h0001);
      chk("bs_count", o_digit_count, 1);
      chk("bs_pulse", {p_valid, p_error}, 0);
      strobe(4'd12);
      chk("bs_clr_value", o_value, 0);
      chk("bs_clr_count", o_digit_count, 0);
      chk("bs_clr_pulse", {p_valid, p_error}, 0);
      strobe(4'd15);
      chk("bs_idle_pulse", {p_valid, p_error}, 0);
      chk("bs_idle_count", o_digit_count, 0);

      // Timeout after 1000 idle cycles, silently
      strobe(4'd8);
      chk("tmo_value0", o_value, 32'h0007);
      seen_pulse = 1'b0;
      for (int i = 0; i < 990; i++) begin
         @(negedge i_clock);
         seen_pulse = seen_pulse | o_error | o_entry_valid;
      end
      chk("tmo_before_count", o_digit_count, 1);
      for (int i = 0; i < 30; i++) begin
         @(negedge i_clock);
         seen_pulse = seen_pulse | o_error | o_entry_valid;
      end
      chk("tmo_after_count", o_digit_count, 0);
      chk("tmo_after_value", o_value, 0);
      chk("tmo_no_pulse", seen_pulse, 0);
      strobe(4'd14);
      chk("empty_enter_error", p_error, 1);
      chk("empty_enter_valid", p_valid, 0);
      chk("empty_enter_entry", o_entry_value, 32'h0123);

      // Reset coincident with Enter while 3 digits are held
      strobe(4'd0); strobe(4'd1); strobe(4'd2);
      chk("pre_rst_count", o_digit_count, 3);
      i_key_code   = 4'd14;
      i_data_ready = 1'b1;
      i_reset      = 1'b1;
      @(negedge i_clock);
      i_data_ready = 1'b0;
      i_reset      = 1'b0;
      chk("rst_enter_value", o_value, 0);
      chk("rst_enter_count", o_digit_count, 0);
      chk("rst_enter_entry", o_entry_value, 0);
      chk("rst_enter_valid", o_entry_valid, 0);
      chk("rst_enter_error", o_error, 0);
      idle(1);
      chk("rst_enter_valid2", o_entry_valid, 0);
      strobe(4'd0);
      chk("post_rst_first_key", o_digit_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
